// File: rtl/button_event_scheduler.sv
// Debounces 4 direct + 8 encoded buttons and queues one event per press,
// granting pending lines round-robin into a small FIFO.
module button_event_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  b_in,
  input  logic        evt_ready,
  input  logic        clr_overflow,
  output logic        evt_valid,
  output logic [3:0]  evt_code,
  output logic [11:0] pressed,
  output logic        overflow
);

  localparam int           NL      = 12;
  localparam int           AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0]   CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]  DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    sync1_q, sync1_d;
  logic [7:0]    sync2_q, sync2_d;
  logic [7:0]    cnt_q [NL];
  logic [7:0]    cnt_d [NL];
  logic [NL-1:0] pressed_q, pressed_d;
  logic [NL-1:0] rise_q, rise_d;
  logic [NL-1:0] pending_q, pending_d;
  logic [3:0]    last_grant_q, last_grant_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [NL-1:0] raw;
  logic [NL-1:0] grant_mask;
  logic [3:0]    grant_idx;
  logic          grant_any, grant, pop, full, empty, ovf_set;

  always_comb begin
    sync1_d = b_in;
    sync2_d = sync1_q;

    raw[3:0] = sync2_q[3:0];
    for (int k = 0; k < 8; k++) begin
      raw[4+k] = sync2_q[7] && (sync2_q[6:4] == 3'(k));
    end

    // A line toggles only after DEBOUNCE_CYCLES consecutive mismatching samples.
    for (int i = 0; i < NL; i++) begin
      cnt_d[i]     = cnt_q[i];
      pressed_d[i] = pressed_q[i];
      rise_d[i]    = 1'b0;
      if (raw[i] == pressed_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == CNT_MAX) begin
        pressed_d[i] = ~pressed_q[i];
        rise_d[i]    = ~pressed_q[i];
        cnt_d[i]     = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end

    empty = (count_q == '0);
    full  = (count_q == DEPTH_C);
    pop   = !empty && evt_ready;

    grant_any = 1'b0;
    grant_idx = 4'd0;
    for (int off = 1; off <= NL; off++) begin
      if (!grant_any && pending_q[(int'(last_grant_q) + off) % NL]) begin
        grant_any = 1'b1;
        grant_idx = 4'((int'(last_grant_q) + off) % NL);
      end
    end
    grant      = grant_any && (!full || pop);
    grant_mask = grant ? (NL'(1) << grant_idx) : '0;

    // A new press on a line whose pending bit is being granted this cycle is
    // a fresh event, not a merge.
    ovf_set    = |(rise_q & pending_q & ~grant_mask);
    overflow_d = ovf_set ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);

    pending_d    = (pending_q & ~grant_mask) | rise_q;
    last_grant_d = grant ? grant_idx : last_grant_q;

    mem_d = mem_q;
    if (grant) begin
      mem_d[wr_ptr_q] = grant_idx;
    end
    wr_ptr_d = wr_ptr_q + AW'(grant);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW + 1)'(grant) - (AW + 1)'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cnt_q        <= '{default: '0};
      pressed_q    <= '0;
      rise_q       <= '0;
      pending_q    <= '0;
      last_grant_q <= 4'd11;
      mem_q        <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      pressed_q    <= pressed_d;
      rise_q       <= rise_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign evt_valid = !empty;
  assign evt_code  = mem_q[rd_ptr_q];
  assign pressed   = pressed_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed scenarios plus a randomized press/glitch phase checked against an
// event-level model (one expected code per accepted press, in press order).
module tb_button_event_scheduler;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  b_in = 8'h00;
  logic        evt_ready = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        evt_valid;
  logic [3:0]  evt_code;
  logic [11:0] pressed;
  logic        overflow;

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];

  button_event_scheduler #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .b_in(b_in), .evt_ready(evt_ready),
    .clr_overflow(clr_overflow), .evt_valid(evt_valid), .evt_code(evt_code),
    .pressed(pressed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] line_bits(input int l);
    logic [7:0] v;
    if (l < 4) v = 8'(1 << l);
    else       v = {1'b1, 3'(l - 4), 4'b0000};
    return v;
  endfunction

  // Random ready each cycle; any pop must match the oldest modelled event.
  task automatic run_cycles(input int n);
    int exp_val;
    for (int c = 0; c < n; c++) begin
      evt_ready = 1'($urandom_range(0, 1));
      if (evt_valid && evt_ready) begin
        exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
        chk("rand_evt_code", 32'(evt_code), 32'(exp_val));
      end
      step(1);
    end
    evt_ready = 1'b0;
  endtask

  initial begin
    int line, hold, kind;
    int seq5 [5];

    // Reset state
    step(3);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_code", 32'(evt_code), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    step(4);

    // Isolated press on line 0: b_in applied after edge 0
    b_in = 8'h01;
    step(17);
    chk("iso_pressed_e17", 32'(pressed), 32'd0);
    step(1);
    chk("iso_pressed_e18", 32'(pressed), 32'h001);
    chk("iso_valid_e18", 32'(evt_valid), 32'd0);
    step(1);
    chk("iso_valid_e19", 32'(evt_valid), 32'd0);
    step(1);
    chk("iso_valid_e20", 32'(evt_valid), 32'd1);
    chk("iso_code_e20", 32'(evt_code), 32'd0);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("iso_popped", 32'(evt_valid), 32'd0);
    b_in = 8'h00;
    step(D + 10);
    chk("iso_release_pressed", 32'(pressed), 32'd0);
    chk("iso_release_noevt", 32'(evt_valid), 32'd0);

    // Glitch on line 2 shorter than the debounce window
    b_in = 8'h04;
    step(10);
    b_in = 8'h00;
    step(30);
    chk("glitch_pressed", 32'(pressed), 32'd0);
    chk("glitch_noevt", 32'(evt_valid), 32'd0);

    // Encoded buttons: index 5 -> line 9, then index 6 -> line 10
    b_in = 8'hD0;
    step(D + 6);
    chk("enc9_pressed", 32'(pressed), 32'h200);
    chk("enc9_valid", 32'(evt_valid), 32'd1);
    chk("enc9_code", 32'(evt_code), 32'd9);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    b_in = 8'hE0;
    step(D + 6);
    chk("enc10_pressed", 32'(pressed), 32'h400);
    chk("enc10_valid", 32'(evt_valid), 32'd1);
    chk("enc10_code", 32'(evt_code), 32'd10);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    b_in = 8'h00;
    step(D + 6);
    chk("enc_release_pressed", 32'(pressed), 32'd0);
    chk("enc_release_noevt", 32'(evt_valid), 32'd0);

    // Five simultaneous presses into a 4-deep queue
    b_in = 8'h8F;
    step(D + 10);
    chk("fill_pressed", 32'(pressed), 32'h01F);
    chk("fill_code_head", 32'(evt_code), 32'd0);
    step(3);
    chk("fill_code_stable", 32'(evt_code), 32'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("fill_valid", 32'(evt_valid), 32'd1);
      chk("fill_code", 32'(evt_code), 32'(i));
      step(1);
    end
    chk("fill_drained", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
    b_in = 8'h00;
    step(D + 6);

    // Overflow: line 1 pressed twice while held pending behind a full queue
    b_in = 8'h8D;
    step(D + 10);
    b_in = 8'h8F;
    step(D + 6);
    chk("ovf_before", 32'(overflow), 32'd0);
    b_in = 8'h8D;
    step(D + 6);
    b_in = 8'h8F;
    step(D + 6);
    chk("ovf_set", 32'(overflow), 32'd1);
    seq5 = '{0, 2, 3, 4, 1};
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("ovf_valid", 32'(evt_valid), 32'd1);
      chk("ovf_code", 32'(evt_code), 32'(seq5[i]));
      step(1);
    end
    chk("ovf_single_evt", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    b_in = 8'h00;
    step(D + 6);

    // Reset mid-operation with three queued events
    b_in = 8'h07;
    step(D + 8);
    chk("mid_valid_before", 32'(evt_valid), 32'd1);
    reset_n = 1'b0;
    b_in = 8'h00;
    #1;
    chk("mid_valid_async", 32'(evt_valid), 32'd0);
    chk("mid_pressed_async", 32'(pressed), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(D + 10);
    chk("mid_no_stale", 32'(evt_valid), 32'd0);
    b_in = 8'h08;
    step(D + 6);
    chk("mid_new_valid", 32'(evt_valid), 32'd1);
    chk("mid_new_code", 32'(evt_code), 32'd3);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    b_in = 8'h00;
    step(D + 6);

    // Randomized presses and glitches, one line active at a time
    for (int it = 0; it < 24; it++) begin
      line = $urandom_range(0, 11);
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        hold = $urandom_range(1, D - 1);
        b_in = line_bits(line);
        run_cycles(hold);
        b_in = 8'h00;
        run_cycles(D + 4);
        chk("rand_glitch_pressed", 32'(pressed), 32'd0);
      end else begin
        hold = $urandom_range(D + 4, D + 12);
        b_in = line_bits(line);
        exp_q.push_back(line);
        run_cycles(hold);
        chk("rand_pressed", 32'(pressed), 32'(12'(1) << line));
        b_in = 8'h00;
        run_cycles($urandom_range(D + 4, D + 12));
        chk("rand_released", 32'(pressed), 32'd0);
      end
    end
    b_in = 8'h00;
    for (int c = 0; c < 20; c++) begin
      evt_ready = 1'b1;
      if (evt_valid) begin
        chk("drain_code", 32'(evt_code), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'd99);
      end
      step(1);
    end
    evt_ready = 1'b0;
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_dut_empty", 32'(evt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
